// File: rtl/dma_bram_port_pkg.sv
// ---------------------------------------------------------------------------
// dma_bram_port_pkg
// Definitions shared by the DMA BRAM front-end and the DMA controller:
// default bus geometry, read-return owner encoding, the arbiter selection
// code and the tag carried down the read-return pipeline.
// ---------------------------------------------------------------------------
package dma_bram_port_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 13;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MEM_DEPTH  = 3072;

    // Which requester a returning read belongs to
    typedef enum logic {
        OWN_DMA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    // Access that owns the BRAM port in the current cycle
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_DMA_WR = 2'd1,
        SEL_DMA_RD = 2'd2,
        SEL_CPU    = 2'd3
    } sel_e;

    // Per-read bookkeeping travelling alongside the BRAM read latency
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oob;
    } rd_tag_t;

endpackage : dma_bram_port_pkg

// File: rtl/dma_bram_rd_pipe.sv
// ---------------------------------------------------------------------------
// dma_bram_rd_pipe
// RD_LATENCY-deep shift register of {valid, owner, oob} tags that tracks
// issued reads so the returning BRAM data can be steered to its requester.
// Ports:
//   wb_clk_i   clock
//   wb_rst_ni  asynchronous active-low reset (discards in-flight reads)
//   issue_tag  tag of the read issued this cycle (valid=0 when none)
//   ret_tag    tag of the read whose data is on bram_rdata this cycle
// ---------------------------------------------------------------------------
module dma_bram_rd_pipe
    import dma_bram_port_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic    wb_clk_i,
    input  logic    wb_rst_ni,
    input  rd_tag_t issue_tag,
    output rd_tag_t ret_tag
);

    rd_tag_t stage_q [RD_LATENCY];

    // Tag shift register, one stage per BRAM latency cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= issue_tag;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign ret_tag = stage_q[RD_LATENCY-1];

endmodule : dma_bram_rd_pipe

// File: rtl/dma_bram_port.sv
// ---------------------------------------------------------------------------
// dma_bram_port
// Single-port BRAM front-end shared by DMA writes, DMA reads and CPU
// accesses. One access per cycle; DMA writes always win because the DMA
// stream side cannot stall. A CPU denied STARVE_MAX consecutive cycles
// outranks DMA reads. Read data returns in issue order after RD_LATENCY.
//
// Optional feature: define DMA_BRAM_PORT_BOUNDS_CHECK_EN to accept but not
// issue accesses at addr >= MEM_DEPTH (reads return 0) and set a sticky
// addr_err. Without it, addresses pass unchecked and addr_err is 0.
//
// Ports:
//   wb_clk_i, wb_rst_ni                       clock, async active-low reset
//   mem_r_ready/addr -> mem_r_ack             DMA read request / accept
//   mem_r_valid, mem_r_data                   DMA read return
//   mem_w_valid/addr/data                     DMA write (never stalled)
//   cpu_req/we/addr/wdata -> cpu_gnt          CPU request / accept
//   cpu_rvalid, cpu_rdata                     CPU read return
//   bram_en/we/addr/wdata, bram_rdata         BRAM port
//   addr_err                                  sticky out-of-range flag
// ---------------------------------------------------------------------------
module dma_bram_port
    import dma_bram_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    mem_r_ready,
    input  logic [ADDR_WIDTH-1:0]   mem_r_addr,
    output logic                    mem_r_ack,
    output logic                    mem_r_valid,
    output logic [DATA_WIDTH-1:0]   mem_r_data,
    input  logic                    mem_w_valid,
    input  logic [ADDR_WIDTH-1:0]   mem_w_addr,
    input  logic [DATA_WIDTH-1:0]   mem_w_data,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wdata,
    input  logic [DATA_WIDTH-1:0]   bram_rdata,
    output logic                    addr_err
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // Elaboration-time parameter sanity
    if (RD_LATENCY < 1 || RD_LATENCY > 4 ||
        64'(MEM_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_param_err
        $error("dma_bram_port: RD_LATENCY or MEM_DEPTH out of range");
    end

    sel_e                  sel;
    logic [SC_W-1:0]       starve_q;
    logic                  cpu_starved;
    logic                  acc_valid;
    logic                  acc_we;
    logic                  acc_oob;
    logic                  acc_issue;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    rd_tag_t               issue_tag;
    rd_tag_t               ret_tag;
    logic [DATA_WIDTH-1:0] rd_data;

    assign cpu_starved = (starve_q == SC_W'(STARVE_MAX));

    // Priority select; held idle in reset so every output reads 0
    always_comb begin
        sel = SEL_NONE;
        if (wb_rst_ni) begin
            if (mem_w_valid) begin
                sel = SEL_DMA_WR;
            end else if (cpu_req && (cpu_starved || !mem_r_ready)) begin
                sel = SEL_CPU;
            end else if (mem_r_ready) begin
                sel = SEL_DMA_RD;
            end
        end
    end

    // Winning access fields and accept strobes
    always_comb begin
        acc_addr  = '0;
        acc_wdata = '0;
        acc_we    = 1'b0;
        mem_r_ack = 1'b0;
        cpu_gnt   = 1'b0;
        unique case (sel)
            SEL_DMA_WR: begin
                acc_addr  = mem_w_addr;
                acc_wdata = mem_w_data;
                acc_we    = 1'b1;
            end
            SEL_DMA_RD: begin
                acc_addr  = mem_r_addr;
                mem_r_ack = 1'b1;
            end
            SEL_CPU: begin
                acc_addr  = cpu_addr;
                acc_wdata = cpu_wdata;
                acc_we    = cpu_we;
                cpu_gnt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign acc_valid = (sel != SEL_NONE);

`ifdef DMA_BRAM_PORT_BOUNDS_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic addr_err_q;

    assign acc_oob = acc_valid && ({1'b0, acc_addr} >= DEPTH_LIM);

    // Sticky until reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            addr_err_q <= 1'b0;
        end else if (acc_oob) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`else
    assign acc_oob  = 1'b0;
    assign addr_err = 1'b0;
`endif

    // Out-of-range accesses are accepted but never reach the BRAM
    assign acc_issue  = acc_valid && !acc_oob;
    assign bram_en    = acc_issue;
    assign bram_we    = (acc_issue && acc_we) ? {BE_W{1'b1}} : '0;
    assign bram_addr  = acc_issue ? acc_addr : '0;
    assign bram_wdata = (acc_issue && acc_we) ? acc_wdata : '0;

    // Consecutive-denial counter, saturating at STARVE_MAX
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            starve_q <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_q <= '0;
        end else if (!cpu_starved) begin
            starve_q <= starve_q + SC_W'(1);
        end
    end

    assign issue_tag = '{
        valid: acc_valid && !acc_we,
        owner: (sel == SEL_CPU) ? OWN_CPU : OWN_DMA,
        oob:   acc_oob
    };

    dma_bram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .issue_tag (issue_tag),
        .ret_tag   (ret_tag)
    );

    // Data is passed through only while a read returns; out-of-range reads return 0
    assign rd_data     = (ret_tag.valid && !ret_tag.oob) ? bram_rdata : '0;
    assign mem_r_valid = ret_tag.valid && (ret_tag.owner == OWN_DMA);
    assign cpu_rvalid  = ret_tag.valid && (ret_tag.owner == OWN_CPU);
    assign mem_r_data  = rd_data;
    assign cpu_rdata   = rd_data;

endmodule : dma_bram_port

// File: tb/tb_dma_bram_port.sv
// ---------------------------------------------------------------------------
// tb_dma_bram_port
// Random and directed stimulus against a reference model of the arbitration
// rules and memory contents; expected read returns are queued at issue and
// checked by an independent monitor when the DUT presents a valid.
// ---------------------------------------------------------------------------
module tb_dma_bram_port;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 3072;
    localparam int LAT   = 2;
    localparam int SMAX  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_r_ready;
    logic [AW-1:0]   mem_r_addr;
    logic            mem_r_ack;
    logic            mem_r_valid;
    logic [DW-1:0]   mem_r_data;
    logic            mem_w_valid;
    logic [AW-1:0]   mem_w_addr;
    logic [DW-1:0]   mem_w_data;
    logic            cpu_req;
    logic            cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic            cpu_gnt;
    logic            cpu_rvalid;
    logic [DW-1:0]   cpu_rdata;
    logic            bram_en;
    logic [DW/8-1:0] bram_we;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_wdata;
    logic [DW-1:0]   bram_rdata;
    logic            addr_err;

    always #5 clk = ~clk;

    dma_bram_port #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .RD_LATENCY (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .mem_r_ready (mem_r_ready),
        .mem_r_addr  (mem_r_addr),
        .mem_r_ack   (mem_r_ack),
        .mem_r_valid (mem_r_valid),
        .mem_r_data  (mem_r_data),
        .mem_w_valid (mem_w_valid),
        .mem_w_addr  (mem_w_addr),
        .mem_w_data  (mem_w_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .addr_err    (addr_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // BRAM behavioural model with LAT-cycle read latency; garbage when idle
    logic [DW-1:0] bram_mem [1<<AW];
    logic [DW-1:0] bpipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) bpipe[i] = bpipe[i-1];
        if (bram_en && bram_we == '0) bpipe[0] = bram_mem[bram_addr];
        else                          bpipe[0] = $urandom;
        if (bram_en && bram_we != '0) bram_mem[bram_addr] = bram_wdata;
    end
    assign bram_rdata = bpipe[LAT-1];

    // Reference model: memory image, starvation count, sticky error
    typedef struct {
        bit            cpu;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [1<<AW];
    int            starve_m   = 0;
    bit            addr_err_m = 1'b0;
    bit            r_acc_m    = 1'b0;
    bit            c_acc_m    = 1'b0;
    int            win;
    bit            is_wr;
    bit            oob_m;
    logic [AW-1:0] a_m;
    logic [DW-1:0] wd_m;

    // Predictor: decide the winner from the rules, check the port, queue returns
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ctl", 64'({mem_r_ack, cpu_gnt, bram_en, bram_we, mem_r_valid, cpu_rvalid, addr_err}), 64'd0);
            chk("rst_bram_addr", 64'(bram_addr), 64'd0);
            chk("rst_bram_wdata", 64'(bram_wdata), 64'd0);
            chk("rst_rdata", {mem_r_data, cpu_rdata}, 64'd0);
            starve_m   = 0;
            addr_err_m = 1'b0;
            r_acc_m    = 1'b0;
            c_acc_m    = 1'b0;
            exp_q.delete();
        end else begin
            if (mem_w_valid)                                         win = 1;
            else if (cpu_req && (starve_m >= SMAX || !mem_r_ready))  win = 3;
            else if (mem_r_ready)                                    win = 2;
            else                                                     win = 0;
            case (win)
                1:       a_m = mem_w_addr;
                2:       a_m = mem_r_addr;
                3:       a_m = cpu_addr;
                default: a_m = '0;
            endcase
            is_wr = (win == 1) || (win == 3 && cpu_we);
            oob_m = 1'b0;
`ifdef DMA_BRAM_PORT_BOUNDS_CHECK_EN
            oob_m = (win != 0) && (int'(a_m) >= DEPTH);
`endif
            chk("mem_r_ack", 64'(mem_r_ack), 64'(win == 2));
            chk("cpu_gnt", 64'(cpu_gnt), 64'(win == 3));
            chk("bram_en", 64'(bram_en), 64'(win != 0 && !oob_m));
            chk("addr_err", 64'(addr_err), 64'(addr_err_m));
            if (win != 0 && !oob_m) begin
                chk("bram_addr", 64'(bram_addr), 64'(a_m));
                chk("bram_we", 64'(bram_we), is_wr ? 64'hF : 64'h0);
                if (is_wr) begin
                    wd_m = (win == 1) ? mem_w_data : cpu_wdata;
                    chk("bram_wdata", 64'(bram_wdata), 64'(wd_m));
                    ref_mem[a_m] = wd_m;
                end
            end
            if (win != 0 && !is_wr)
                exp_q.push_back('{cpu: (win == 3), data: (oob_m ? '0 : ref_mem[a_m]), due: cyc + LAT});
            if (oob_m) addr_err_m = 1'b1;
            if (cpu_req && win != 3) starve_m = (starve_m < SMAX) ? starve_m + 1 : SMAX;
            else                     starve_m = 0;
            r_acc_m = (win == 2);
            c_acc_m = (win == 3);
        end
    end

    // Monitor: every presented return must match the oldest queued read
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_overlap", 64'(mem_r_valid & cpu_rvalid), 64'd0);
            if (mem_r_valid || cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'({mem_r_valid, cpu_rvalid}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_owner", 64'(cpu_rvalid), 64'(e.cpu));
                    chk("ret_cycle", 64'(cyc), 64'(e.due));
                    chk("ret_data", 64'(e.cpu ? cpu_rdata : mem_r_data), 64'(e.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_valid", 64'({mem_r_valid, cpu_rvalid}), e.cpu ? 64'd1 : 64'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_r_ready = 1'b0;
        mem_w_valid = 1'b0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
    endtask

    logic [DW-1:0] v;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            v = $urandom;
            bram_mem[i] = v;
            ref_mem[i]  = v;
        end
        for (int i = 0; i < LAT; i++) bpipe[i] = '0;

        // Reset with every requester active
        rst_n       = 1'b0;
        mem_r_ready = 1'b1;
        mem_r_addr  = AW'(5);
        mem_w_valid = 1'b1;
        mem_w_addr  = AW'(6);
        mem_w_data  = 32'h1234_5678;
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = AW'(7);
        cpu_wdata   = 32'hCAFE_F00D;
        repeat (3) tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();

        // Preload 0x100..0x103 through DMA writes
        for (int k = 0; k < 4; k++) begin
            mem_w_valid = 1'b1;
            mem_w_addr  = AW'(32'h100 + k);
            mem_w_data  = 32'hA0 + k;
            tick();
        end
        mem_w_valid = 1'b0;

        // DMA read burst
        mem_r_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_r_addr = AW'(32'h100 + k);
            mid();
            chk("burst_ack", 64'(mem_r_ack), 64'd1);
            tick();
        end
        mem_r_ready = 1'b0;
        repeat (LAT + 1) tick();

        // DMA write and read to the same address in one cycle
        mem_w_valid = 1'b1;
        mem_w_addr  = AW'(32'h10);
        mem_w_data  = 32'h55;
        mem_r_ready = 1'b1;
        mem_r_addr  = AW'(32'h10);
        mid();
        chk("conflict_no_ack", 64'(mem_r_ack), 64'd0);
        tick();
        mem_w_valid = 1'b0;
        mid();
        chk("conflict_reissue_ack", 64'(mem_r_ack), 64'd1);
        tick();
        mem_r_ready = 1'b0;
        repeat (LAT - 1) tick();
        mid();
        chk("conflict_valid", 64'(mem_r_valid), 64'd1);
        chk("conflict_data", 64'(mem_r_data), 64'h55);
        tick();

        // CPU starvation against continuous DMA reads
        mem_r_ready = 1'b1;
        mem_r_addr  = AW'(32'h20);
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = AW'(32'h101);
        for (int k = 0; k < SMAX; k++) begin
            mid();
            chk("starve_denied", 64'(cpu_gnt), 64'd0);
            chk("starve_rd_ack", 64'(mem_r_ack), 64'd1);
            tick();
        end
        mid();
        chk("starve_gnt", 64'(cpu_gnt), 64'd1);
        chk("starve_rd_blocked", 64'(mem_r_ack), 64'd0);
        tick();
        cpu_req = 1'b0;
        repeat (LAT - 1) tick();
        mid();
        chk("starve_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("starve_rdata", 64'(cpu_rdata), 64'hA1);
        tick();
        mem_r_ready = 1'b0;
        repeat (LAT + 1) tick();

        // Back-to-back DMA writes hold off the CPU, then read them back
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = AW'(32'h40);
        for (int k = 0; k < 8; k++) begin
            mem_w_valid = 1'b1;
            mem_w_addr  = AW'(32'h200 + k);
            mem_w_data  = $urandom;
            mid();
            chk("wprio_no_gnt", 64'(cpu_gnt), 64'd0);
            tick();
        end
        idle_inputs();
        mem_r_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_r_addr = AW'(32'h200 + k);
            mid();
            chk("readback_ack", 64'(mem_r_ack), 64'd1);
            tick();
        end
        mem_r_ready = 1'b0;
        repeat (LAT + 1) tick();

        // Random traffic; requests held until the model says accepted
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!mem_r_ready || r_acc_m) begin
                mem_r_ready = ($urandom_range(0, 99) < 60);
                mem_r_addr  = AW'($urandom_range(0, 63));
            end
            if (!cpu_req || c_acc_m) begin
                cpu_req   = ($urandom_range(0, 99) < 40);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, 63));
                cpu_wdata = $urandom;
            end
            mem_w_valid = ($urandom_range(0, 99) < 25);
            mem_w_addr  = AW'($urandom_range(0, 63));
            mem_w_data  = $urandom;
        end
        tick();
        idle_inputs();
        repeat (LAT + 2) tick();

`ifdef DMA_BRAM_PORT_BOUNDS_CHECK_EN
        // CPU read just past the implemented depth
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = AW'(DEPTH);
        mid();
        chk("oob_gnt", 64'(cpu_gnt), 64'd1);
        chk("oob_bram_en", 64'(bram_en), 64'd0);
        tick();
        cpu_req = 1'b0;
        repeat (LAT - 1) tick();
        mid();
        chk("oob_rvalid", 64'(cpu_rvalid), 64'd1);
        chk("oob_rdata", 64'(cpu_rdata), 64'd0);
        chk("oob_addr_err", 64'(addr_err), 64'd1);
        repeat (5) tick();
        mid();
        chk("oob_err_sticky", 64'(addr_err), 64'd1);
        tick();
`endif

        // Reset one cycle after a DMA read is accepted
        mem_r_ready = 1'b1;
        mem_r_addr  = AW'(32'h100);
        mid();
        chk("flight_ack", 64'(mem_r_ack), 64'd1);
        tick();
        rst_n       = 1'b0;
        mem_w_valid = 1'b1;
        cpu_req     = 1'b1;
        repeat (2) tick();
        idle_inputs();
        rst_n = 1'b1;
        repeat (LAT + 4) begin
            mid();
            chk("post_rst_no_valid", 64'({mem_r_valid, cpu_rvalid}), 64'd0);
            tick();
        end

        repeat (LAT + 2) tick();
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dma_bram_port
